// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of ctrl. It owns the PC,
// issues one instruction-memory request at a time over a req/rvalid
// handshake, latches the returned word and exposes it, together with the
// op/funct3/funct7 decode fields, until the backend retires it. When an
// instruction retires, the PC moves to pc+4 or to the word-aligned PCTarget,
// depending on PCSrc.
//
// Sequencing: RST -> FETCH -> WAIT -> VALID -> FETCH ...
//   FETCH : one-cycle imem_req pulse, imem_addr = pc
//   WAIT  : wait for imem_rvalid, then capture imem_rdata
//   VALID : instr_valid = 1; hold while stall, retire when stall is low
//
// Ports
//   clk          in   1     clock, all state changes on posedge
//   rst_n        in   1     synchronous active-low reset
//   imem_req     out  1     one-cycle request pulse to instruction memory
//   imem_addr    out  XLEN  request address (always equal to pc)
//   imem_rvalid  in   1     instruction memory response valid
//   imem_rdata   in   32    instruction memory response word
//   stall        in   1     backend not ready, keep the current instruction
//   PCSrc        in   1     1 = next pc is PCTarget, 0 = next pc is pc+4
//   PCTarget     in   XLEN  branch/jump target from the datapath
//   instr        out  32    latched instruction word
//   instr_valid  out  1     instr and its decode fields are valid
//   pc           out  XLEN  address of instr
//   pc_plus4     out  XLEN  pc + 4 (wraps modulo 2^XLEN)
//   op           out  7     instr[6:0]
//   funct3       out  3     instr[14:12]
//   funct7       out  1     instr[30]
//   misalign     out  1     sticky: a taken PCTarget had nonzero low bits
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic            misalign
);

    // Canonical RISC-V nop (addi x0, x0, 0) shown while no word has been fetched.
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } state_e;

    state_e          state_q,       state_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic [31:0]     instr_q,       instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q,    imem_req_d;
    logic            misalign_q,    misalign_d;

    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] target_aligned_s;
    logic [XLEN-1:0] next_pc_s;
    logic            target_misaligned_s;

    // PC arithmetic and next-PC selection used on retirement.
    always_comb begin
        pc_plus4_s          = pc_q + PC_STEP;
        target_aligned_s    = {PCTarget[XLEN-1:2], 2'b00};
        target_misaligned_s = (PCTarget[1:0] != 2'b00);
        if (PCSrc) begin
            next_pc_s = target_aligned_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Next-state, next-PC and capture logic for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;

        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A response in the request cycle itself is not accepted;
                // memory latency is at least one cycle.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_VALID;
                    instr_d = imem_rdata;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_VALID: begin
                // PCSrc/PCTarget only matter on the retiring cycle.
                if (!stall) begin
                    state_d = ST_FETCH;
                    pc_d    = next_pc_s;
                    if (PCSrc && target_misaligned_s) begin
                        misalign_d = 1'b1;
                    end else begin
                        misalign_d = misalign_q;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end
            default: begin
                // Unreachable encoding: restart cleanly through RST.
                state_d = ST_RST;
            end
        endcase

        // Registered handshake outputs follow the state being entered.
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_VALID);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed plus randomized bench for fetch_unit. Two instances share the
// input stimulus: dut_a uses RESET_PC = 0 and dut_b uses RESET_PC =
// 32'hFFFF_FFFC. Only one is out of reset at a time and the observed outputs
// are taken from the active one. The bench plays the instruction memory and
// keeps its own model of the architectural state (pc, current instruction,
// sticky misalign flag) updated per retired instruction.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        imem_rvalid, stall, pcsrc;
    logic [31:0] imem_rdata, pc_target;

    logic        a_req, a_valid, a_f7, a_mis;
    logic [31:0] a_addr, a_instr, a_pc, a_pc4;
    logic [6:0]  a_op;
    logic [2:0]  a_f3;
    logic        b_req, b_valid, b_f7, b_mis;
    logic [31:0] b_addr, b_instr, b_pc, b_pc4;
    logic [6:0]  b_op;
    logic [2:0]  b_f3;

    logic        sel_b;
    logic        o_req, o_valid, o_f7, o_mis;
    logic [31:0] o_addr, o_instr, o_pc, o_pc4;
    logic [6:0]  o_op;
    logic [2:0]  o_f3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_mis;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC_A)) dut_a (
        .clk(clk), .rst_n(rst_a_n),
        .imem_req(a_req), .imem_addr(a_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .PCSrc(pcsrc), .PCTarget(pc_target),
        .instr(a_instr), .instr_valid(a_valid), .pc(a_pc), .pc_plus4(a_pc4),
        .op(a_op), .funct3(a_f3), .funct7(a_f7), .misalign(a_mis)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC_B)) dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .PCSrc(pcsrc), .PCTarget(pc_target),
        .instr(b_instr), .instr_valid(b_valid), .pc(b_pc), .pc_plus4(b_pc4),
        .op(b_op), .funct3(b_f3), .funct7(b_f7), .misalign(b_mis)
    );

    assign o_req   = sel_b ? b_req   : a_req;
    assign o_valid = sel_b ? b_valid : a_valid;
    assign o_f7    = sel_b ? b_f7    : a_f7;
    assign o_mis   = sel_b ? b_mis   : a_mis;
    assign o_addr  = sel_b ? b_addr  : a_addr;
    assign o_instr = sel_b ? b_instr : a_instr;
    assign o_pc    = sel_b ? b_pc    : a_pc;
    assign o_pc4   = sel_b ? b_pc4   : a_pc4;
    assign o_op    = sel_b ? b_op    : a_op;
    assign o_f3    = sel_b ? b_f3    : a_f3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold the active DUT in reset, check reset outputs, then release at a negedge.
    task automatic do_reset(input logic [31:0] rpc);
        if (sel_b) rst_b_n = 1'b0; else rst_a_n = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_instr",    o_instr, NOP);
        check("rst_valid",    o_valid, 32'd0);
        check("rst_req",      o_req,   32'd0);
        check("rst_misalign", o_mis,   32'd0);
        check("rst_pc",       o_pc,    rpc);
        m_pc    = rpc;
        m_instr = NOP;
        m_mis   = 1'b0;
        if (sel_b) rst_b_n = 1'b1; else rst_a_n = 1'b1;
    endtask

    // Serve one fetch: wait for the request, answer after lat cycles, check VALID.
    task automatic fetch(input int lat, input logic [31:0] data, input bit early_spur,
                         output int waited);
        waited = 0;
        while (!o_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen",      o_req,   32'd1);
        check("imem_addr",     o_addr,  m_pc);
        check("valid_in_fetch", o_valid, 32'd0);
        if (early_spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~data;
        end
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("req_one_cycle", o_req, 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check("valid_in_wait", o_valid, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        m_instr     = data;
        check("valid",    o_valid, 32'd1);
        check("instr",    o_instr, m_instr);
        check("pc",       o_pc,    m_pc);
        check("pc_plus4", o_pc4,   m_pc + 32'd4);
        check("op",       32'(o_op), 32'(m_instr[6:0]));
        check("funct3",   32'(o_f3), 32'(m_instr[14:12]));
        check("funct7",   32'(o_f7), 32'(m_instr[30]));
        check("misalign", o_mis,   32'(m_mis));
    endtask

    // In VALID: optionally stall (with ignored noise), then retire.
    task automatic retire(input int stall_cycles, input bit src, input logic [31:0] tgt);
        if (stall_cycles > 0) stall = 1'b1;
        for (int k = 0; k < stall_cycles; k++) begin
            pcsrc       = 1'($urandom_range(0, 1));
            pc_target   = $urandom;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clk);
            check("stall_valid", o_valid, 32'd1);
            check("stall_instr", o_instr, m_instr);
            check("stall_pc",    o_pc,    m_pc);
            check("stall_noreq", o_req,   32'd0);
        end
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        pcsrc       = src;
        pc_target   = tgt;
        if (src) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
        pcsrc     = 1'($urandom_range(0, 1));
        pc_target = $urandom;
        check("retire_valid_low", o_valid, 32'd0);
        check("retire_req",       o_req,   32'd1);
        check("retire_pc",        o_pc,    m_pc);
        check("retire_misalign",  o_mis,   32'(m_mis));
    endtask

    initial begin
        int          w;
        int          lat;
        int          stc;
        logic [31:0] d;
        logic [31:0] t;
        bit          src;
        bit          spur;

        rst_a_n     = 1'b0;
        rst_b_n     = 1'b0;
        sel_b       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        stall       = 1'b0;
        pcsrc       = 1'b0;
        pc_target   = 32'd0;
        m_pc        = 32'd0;
        m_instr     = NOP;
        m_mis       = 1'b0;

        // Test 1: reset, 1-cycle-late addi response, instr_valid 3 edges after release.
        do_reset(RESET_PC_A);
        fetch(1, 32'h00A0_0093, 1'b0, w);
        check("t1_req_delay", w, 32'd1);
        check("t1_op", 32'(o_op), 32'h13);
        check("t1_funct3", 32'(o_f3), 32'd0);
        retire(0, 1'b0, 32'd0);

        // Test 2: three sequential words.
        for (int i = 0; i < 3; i++) begin
            fetch(1, $urandom, 1'b0, w);
            retire(0, 1'b0, 32'd0);
        end

        // Test 3: taken branch to 0x40.
        fetch(1, 32'h0000_0063, 1'b0, w);
        retire(0, 1'b1, 32'h0000_0040);
        check("t3_addr", o_addr, 32'h0000_0040);
        check("t3_misalign", o_mis, 32'd0);

        // Test 4: five-cycle stall in VALID.
        fetch(2, $urandom, 1'b0, w);
        retire(5, 1'b0, 32'd0);

        // Test 5: misaligned target, spurious rvalid while held in VALID.
        fetch(1, $urandom, 1'b1, w);
        retire(3, 1'b1, 32'h0000_0042);
        check("t5_addr", o_addr, 32'h0000_0040);
        check("t5_misalign", o_mis, 32'd1);
        fetch(3, $urandom, 1'b0, w);
        retire(0, 1'b0, 32'd0);
        fetch(1, $urandom, 1'b0, w);
        retire(0, 1'b0, 32'd0);
        check("t5_misalign_sticky", o_mis, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            lat  = $urandom_range(1, 4);
            spur = 1'($urandom_range(0, 1));
            stc  = $urandom_range(0, 3);
            src  = 1'($urandom_range(0, 1));
            t    = $urandom;
            d    = $urandom;
            fetch(lat, d, spur, w);
            retire(stc, src, t);
        end

        // Reset during VALID clears instr, valid and the sticky flag.
        fetch(1, $urandom, 1'b0, w);
        rst_a_n = 1'b0;
        @(negedge clk);
        check("rstv_valid", o_valid, 32'd0);
        check("rstv_instr", o_instr, NOP);
        check("rstv_pc", o_pc, RESET_PC_A);
        check("rstv_misalign", o_mis, 32'd0);

        // Test 6: RESET_PC = 0xFFFF_FFFC wraps to 0; reset during WAIT.
        sel_b = 1'b1;
        do_reset(RESET_PC_B);
        fetch(1, $urandom, 1'b0, w);
        check("t6_pc4_wrap", o_pc4, 32'd0);
        retire(0, 1'b0, 32'd0);
        check("t6_addr_wrap", o_addr, 32'd0);
        w = 0;
        while (!o_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t6_req", o_req, 32'd1);
        @(negedge clk);
        rst_b_n = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", o_valid, 32'd0);
        check("t6_rst_req", o_req, 32'd0);
        check("t6_rst_instr", o_instr, NOP);
        m_pc    = RESET_PC_B;
        m_instr = NOP;
        m_mis   = 1'b0;
        rst_b_n = 1'b1;
        fetch(1, $urandom, 1'b0, w);
        check("t6_refetch_delay", w, 32'd1);
        retire(0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
